mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory access unit answering the microcoded control strobes (MAR_LOAD, MDR_LOAD, RE, RAM_LOAD, BE) produced by the CPU decoder. It holds the MAR and MDR, runs one read or write per request against an external word-organised memory with a req/ack handshake, and handles byte lanes. A bus timeout raises fault_r back to the decoder. Sits between the datapath and the RAM/MMIO fabric.

## Interface
- AW, 16, byte address width
- DW, 16, data width (fixed 16; two byte lanes)
- TIMEOUT, 15, max cycles waiting for mem_ack before fault (only with MEMCTL_TIMEOUT_EN)
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- MAR_LOAD  in  1  latch addr_in into MAR
- MDR_LOAD  in  1  latch wdata_in into MDR
- RE  in  1  read request, level; access starts on 0->1 edge
- RAM_LOAD  in  1  write request, one-cycle pulse
- BE  in  1  1 = byte access, 0 = word access
- addr_in  in  AW  address source for MAR
- wdata_in  in  DW  data source for MDR
- rdata_out  out  DW  current MDR contents
- busy  out  1  access in flight; CPU stalls
- fault_r  out  1  one-cycle timeout pulse
- fault_addr  out  AW  MAR value of the faulting access
- mem_req  out  1  request valid
- mem_we  out  1  1 = write
- mem_addr  out  AW-1  word address (MAR[AW-1:1])
- mem_wstrb  out  2  byte-lane strobes, bit1 = high lane
- mem_wdata  out  DW  write data
- mem_ack  in  1  responder accepts/completes the access
- mem_rdata  in  DW  read data, valid with mem_ack

## Operation
- Reset: state IDLE, MAR=0, MDR=0, busy=0, fault_r=0, fault_addr=0, mem_req=0, mem_we=0, mem_addr=0, mem_wstrb=0, mem_wdata=0, RE edge register=0.
- FSM: IDLE, REQ. IDLE->REQ on RAM_LOAD or RE rising edge; REQ->IDLE on mem_ack or timeout.
- On IDLE->REQ, mem_addr, mem_we, mem_wstrb, mem_wdata are copied from MAR/MDR/BE and held stable until exit; later MAR_LOAD/MDR_LOAD do not disturb the in-flight access.
- RAM_LOAD and RE edge in the same cycle: write wins; read edge is dropped.
- Requests arriving in REQ are ignored (no queue); RE edge register still tracks RE.
- Word write: mem_wstrb=2'b11, mem_wdata=MDR. Byte write: MDR[7:0] replicated to both lanes, mem_wstrb = MAR[0] ? 2'b10 : 2'b01.
- Word read: MDR <= mem_rdata. Byte read: MDR <= {8'h00, lane}, lane = MAR[0] ? mem_rdata[15:8] : mem_rdata[7:0]. Word accesses ignore MAR[0].
- MDR_LOAD during REQ updates MDR; a completing read overwrites it at ack.
- MAR_LOAD and MDR_LOAD in IDLE in the same cycle as a request: the request uses the newly loaded values (load takes effect first).
- Reset mid-access: mem_req drops at that edge; access abandoned, no fault.

## Timing
- Request sampled at edge N -> mem_req=1, busy=1 after N.
- mem_ack sampled at edge N+k (k>=1): MDR updated and mem_req=0, busy=0 after that edge. Minimum read/write latency 2 cycles, request edge to busy low.
- Timeout: cycle counter cleared on entry to REQ, increments each REQ cycle without ack; at count == TIMEOUT, mem_req drops, fault_r=1 for exactly one cycle, fault_addr=MAR copy, return to IDLE, MDR unchanged. mem_ack on the same edge as timeout: ack wins, no fault.
- rdata_out is the MDR register, no combinational path from mem_rdata.

## Configuration
- MEMCTL_TIMEOUT_EN defined: timeout counter, fault_r, fault_addr active as above.
- Undefined: counter removed, REQ waits indefinitely for mem_ack, fault_r and fault_addr tied to 0.

## Structure
- Package mem_ctrl_pkg: state enum (IDLE, REQ), strobe constants WSTRB_WORD=2'b11, WSTRB_LO=2'b01, WSTRB_HI=2'b10.
- One sub-module mem_byte_lane: combinational write replication/strobe generation and read lane extraction from BE and addr[0].

## Test plan
- Word read: MAR_LOAD addr 0x0102, RE rises, ack after 3 cycles with 0xBEEF -> mem_addr=0x0081, mem_we=0, mem_wstrb=2'b11, rdata_out=0xBEEF, busy high exactly 4 cycles.
- Byte write high lane: MAR=0x0011, MDR=0x12AB, BE=1, RAM_LOAD -> mem_wstrb=2'b10, mem_wdata=0xABAB, mem_addr=0x0008.
- Byte read: MAR=0x0011, BE=1, ack with 0x5A3C -> rdata_out=0x005A; MAR=0x0010 -> 0x003C.
- RE held high 5 cycles, ack immediately -> exactly one mem_req transaction; RAM_LOAD and RE rising together -> only the write issued.
- Timeout (MEMCTL_TIMEOUT_EN, TIMEOUT=15), no ack -> mem_req drops and fault_r pulses 1 cycle 15 cycles after entry, fault_addr=MAR; ack on cycle 15 -> no fault.
- Reset asserted while mem_req=1 -> all outputs at reset values next cycle, no fault_r.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory access unit.
package mem_ctrl_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StReq
  } state_e;

  localparam logic [1:0] WSTRB_WORD = 2'b11;
  localparam logic [1:0] WSTRB_LO   = 2'b01;
  localparam logic [1:0] WSTRB_HI   = 2'b10;

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane steering: write-side replication/strobes and read-side lane extraction.
module mem_byte_lane
  import mem_ctrl_pkg::*;
(
  input  logic        i_wr_be,
  input  logic        i_wr_addr0,
  input  logic [15:0] i_wr_data,
  input  logic        i_rd_be,
  input  logic        i_rd_addr0,
  input  logic [15:0] i_rd_data,
  output logic [1:0]  o_wstrb,
  output logic [15:0] o_wdata,
  output logic [15:0] o_rdata
);

  always_comb begin
    o_wstrb = WSTRB_WORD;
    o_wdata = i_wr_data;
    if (i_wr_be) begin
      o_wstrb = i_wr_addr0 ? WSTRB_HI : WSTRB_LO;
      o_wdata = {2{i_wr_data[7:0]}};
    end
  end

  always_comb begin
    o_rdata = i_rd_data;
    if (i_rd_be) begin
      o_rdata = {8'h00, (i_rd_addr0 ? i_rd_data[15:8] : i_rd_data[7:0])};
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// MAR/MDR memory access unit with req/ack handshake and byte lanes.
// Optional bus timeout enabled by defining MEMCTL_TIMEOUT_EN.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
`ifdef MEMCTL_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 15
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MAR_LOAD,
  input  logic          MDR_LOAD,
  input  logic          RE,
  input  logic          RAM_LOAD,
  input  logic          BE,
  input  logic [AW-1:0] addr_in,
  input  logic [DW-1:0] wdata_in,
  output logic [DW-1:0] rdata_out,
  output logic          busy,
  output logic          fault_r,
  output logic [AW-1:0] fault_addr,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-2:0] mem_addr,
  output logic [1:0]    mem_wstrb,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);

  state_e        r_state, w_state_d;
  logic [AW-1:0] r_mar, r_acc_addr, w_mar_eff;
  logic [DW-1:0] r_mdr, r_wdata, w_mdr_eff;
  logic          r_re_q, r_we, r_be;
  logic [1:0]    r_wstrb;
  logic          w_re_rise, w_start, w_done, w_timeout;
  logic [1:0]    w_wstrb;
  logic [DW-1:0] w_wdata_lane, w_rdata_lane;

  // Loads in the same cycle as a request take effect before the request is captured.
  always_comb begin
    w_mar_eff = MAR_LOAD ? addr_in : r_mar;
    w_mdr_eff = MDR_LOAD ? wdata_in : r_mdr;
    w_re_rise = RE & ~r_re_q;
    w_start   = (r_state == StIdle) & (RAM_LOAD | w_re_rise);
    w_done    = (r_state == StReq) & mem_ack;
  end

  mem_byte_lane u_lane (
    .i_wr_be    (BE),
    .i_wr_addr0 (w_mar_eff[0]),
    .i_wr_data  (w_mdr_eff),
    .i_rd_be    (r_be),
    .i_rd_addr0 (r_acc_addr[0]),
    .i_rd_data  (mem_rdata),
    .o_wstrb    (w_wstrb),
    .o_wdata    (w_wdata_lane),
    .o_rdata    (w_rdata_lane)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (w_start) w_state_d = StReq;
      StReq:  if (mem_ack || w_timeout) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mar      <= '0;
      r_mdr      <= '0;
      r_re_q     <= 1'b0;
      r_acc_addr <= '0;
      r_we       <= 1'b0;
      r_be       <= 1'b0;
      r_wstrb    <= '0;
      r_wdata    <= '0;
    end else begin
      r_re_q <= RE;
      if (MAR_LOAD) r_mar <= addr_in;
      // A completing read overrides a concurrent MDR load.
      if (w_done && !r_we) begin
        r_mdr <= w_rdata_lane;
      end else if (MDR_LOAD) begin
        r_mdr <= wdata_in;
      end
      // Write wins over a simultaneous read edge.
      if (w_start) begin
        r_acc_addr <= w_mar_eff;
        r_we       <= RAM_LOAD;
        r_be       <= BE;
        r_wstrb    <= w_wstrb;
        r_wdata    <= w_wdata_lane;
      end
    end
  end

`ifdef MEMCTL_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] r_cnt;
  logic            r_fault;
  logic [AW-1:0]   r_fault_addr;

  assign w_timeout = (r_state == StReq) && !mem_ack && (r_cnt == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else begin
      r_fault <= w_timeout;
      if (w_start) begin
        r_cnt <= '0;
      end else if ((r_state == StReq) && !mem_ack) begin
        r_cnt <= r_cnt + CntW'(1);
      end
      if (w_timeout) r_fault_addr <= r_acc_addr;
    end
  end

  assign fault_r    = r_fault;
  assign fault_addr = r_fault_addr;
`else
  assign w_timeout  = 1'b0;
  assign fault_r    = 1'b0;
  assign fault_addr = '0;
`endif

  assign rdata_out = r_mdr;
  assign mem_req   = (r_state == StReq);
  assign busy      = (r_state == StReq);
  assign mem_we    = r_we;
  assign mem_addr  = r_acc_addr[AW-1:1];
  assign mem_wstrb = r_wstrb;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized self-checking bench for mem_ctrl against a byte-addressed memory model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MAR_LOAD = 1'b0, MDR_LOAD = 1'b0, RE = 1'b0, RAM_LOAD = 1'b0, BE = 1'b0;
  logic [15:0] addr_in = '0, wdata_in = '0;
  logic [15:0] rdata_out;
  logic        busy, fault_r;
  logic [15:0] fault_addr;
  logic        mem_req, mem_we;
  logic [14:0] mem_addr;
  logic [1:0]  mem_wstrb;
  logic [15:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;

  int total = 0;
  int bad = 0;
  logic [15:0] mem [256];

  mem_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .MAR_LOAD   (MAR_LOAD),
    .MDR_LOAD   (MDR_LOAD),
    .RE         (RE),
    .RAM_LOAD   (RAM_LOAD),
    .BE         (BE),
    .addr_in    (addr_in),
    .wdata_in   (wdata_in),
    .rdata_out  (rdata_out),
    .busy       (busy),
    .fault_r    (fault_r),
    .fault_addr (fault_addr),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // One complete access; ack is sampled on the lat-th edge after the request edge.
  task automatic access(input bit we, input bit be, input logic [15:0] addr,
                        input logic [15:0] wd, input int lat, input bit split, input bit disturb);
    logic [15:0] word, exp_rd, exp_wd;
    logic [1:0]  exp_strb;
    int          busy_cnt;
    word     = mem[addr[8:1]];
    exp_strb = !be ? 2'b11 : (addr[0] ? 2'b10 : 2'b01);
    exp_wd   = be ? {wd[7:0], wd[7:0]} : wd;
    if (we) exp_rd = wd;
    else if (!be) exp_rd = word;
    else exp_rd = addr[0] ? (word >> 8) : (word & 16'h00ff);
    MAR_LOAD = 1'b1; addr_in = addr; wdata_in = wd;
    if (split) begin
      MDR_LOAD = 1'b1;
      tick();
      MAR_LOAD = 1'b0; MDR_LOAD = 1'b0;
    end else begin
      MDR_LOAD = we;
    end
    BE = be; RAM_LOAD = we; RE = !we;
    tick();
    MAR_LOAD = 1'b0; MDR_LOAD = 1'b0; RAM_LOAD = 1'b0;
    addr_in = 16'($urandom); wdata_in = 16'($urandom);
    busy_cnt = 0;
    for (int i = 0; i < lat; i++) begin
      if (busy) busy_cnt++;
      total++;
      if ({mem_req, mem_we, mem_addr, mem_wstrb} !== {1'b1, we, addr[15:1], exp_strb}) begin
        bad++;
        $display("FAIL acc_bus: got req=%b we=%b addr=%h strb=%b want req=1 we=%b addr=%h strb=%b",
                 mem_req, mem_we, mem_addr, mem_wstrb, we, addr[15:1], exp_strb);
      end
      if (we) begin
        total++;
        if (mem_wdata !== exp_wd) begin
          bad++;
          $display("FAIL acc_wdata: got %h want %h", mem_wdata, exp_wd);
        end
      end
      MAR_LOAD = disturb & 1'($urandom);
      BE = disturb ? 1'($urandom) : be;
      if (i == lat - 1) begin
        mem_ack = 1'b1;
        mem_rdata = we ? 16'($urandom) : word;
      end
      tick();
    end
    mem_ack = 1'b0; MAR_LOAD = 1'b0; RE = 1'b0;
    mem_rdata = 16'($urandom);
    total++;
    if (busy !== 1'b0 || busy_cnt != lat) begin
      bad++;
      $display("FAIL acc_busy: got busy=%b cycles=%0d want busy=0 cycles=%0d", busy, busy_cnt, lat);
    end
    total++;
    if (rdata_out !== exp_rd) begin
      bad++;
      $display("FAIL acc_rdata: got %h want %h", rdata_out, exp_rd);
    end
    total++;
    if (fault_r !== 1'b0) begin
      bad++;
      $display("FAIL acc_nofault: got %b want 0", fault_r);
    end
    if (we) begin
      if (!be) mem[addr[8:1]] = wd;
      else if (addr[0]) mem[addr[8:1]][15:8] = wd[7:0];
      else mem[addr[8:1]][7:0] = wd[7:0];
    end
    tick();
  endtask

  task automatic test_reset();
    total++;
    if ({busy, fault_r, mem_req, mem_we, mem_wstrb} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctl: got busy=%b fault=%b req=%b we=%b strb=%b want all 0",
               busy, fault_r, mem_req, mem_we, mem_wstrb);
    end
    total++;
    if ({rdata_out, fault_addr, mem_addr, mem_wdata} !== 63'b0) begin
      bad++;
      $display("FAIL reset_data: got rdata=%h faddr=%h addr=%h wdata=%h want 0",
               rdata_out, fault_addr, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_directed();
    mem[8'h81] = 16'hBEEF;
    access(1'b0, 1'b0, 16'h0102, 16'h0000, 4, 1'b1, 1'b0);
    access(1'b1, 1'b1, 16'h0011, 16'h12AB, 2, 1'b0, 1'b0);
    mem[8'h08] = 16'h5A3C;
    access(1'b0, 1'b1, 16'h0011, 16'h0000, 1, 1'b0, 1'b0);
    access(1'b0, 1'b1, 16'h0010, 16'h0000, 3, 1'b1, 1'b0);
  endtask

  task automatic test_re_level();
    int txn;
    logic prev;
    MAR_LOAD = 1'b1; addr_in = 16'h0040; BE = 1'b0;
    tick();
    MAR_LOAD = 1'b0; mem_ack = 1'b1; mem_rdata = mem[8'h20]; RE = 1'b1;
    txn = 0; prev = 1'b0;
    repeat (6) begin
      tick();
      if (mem_req && !prev) txn++;
      prev = mem_req;
    end
    total++;
    if (txn != 1) begin
      bad++;
      $display("FAIL re_level_txn: got %0d transactions want 1", txn);
    end
    total++;
    if (rdata_out !== mem[8'h20]) begin
      bad++;
      $display("FAIL re_level_rdata: got %h want %h", rdata_out, mem[8'h20]);
    end
    RE = 1'b0; mem_ack = 1'b0;
    tick();
    MAR_LOAD = 1'b1; addr_in = 16'h0042; MDR_LOAD = 1'b1; wdata_in = 16'h7E57;
    RAM_LOAD = 1'b1; RE = 1'b1;
    tick();
    MAR_LOAD = 1'b0; MDR_LOAD = 1'b0; RAM_LOAD = 1'b0;
    total++;
    if ({mem_req, mem_we, mem_addr} !== {2'b11, 15'h0021}) begin
      bad++;
      $display("FAIL collide_write: got req=%b we=%b addr=%h want req=1 we=1 addr=0021",
               mem_req, mem_we, mem_addr);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    mem[8'h21] = 16'h7E57;
    txn = 0;
    repeat (4) begin
      tick();
      if (mem_req) txn++;
    end
    total++;
    if (txn != 0) begin
      bad++;
      $display("FAIL collide_noread: got %0d request cycles want 0", txn);
    end
    RE = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int extra;
    mem[8'h18] = 16'h2468;
    MAR_LOAD = 1'b1; addr_in = 16'h0030; BE = 1'b0; RE = 1'b1;
    tick();
    MAR_LOAD = 1'b0; MDR_LOAD = 1'b1; wdata_in = 16'h1111; RAM_LOAD = 1'b1;
    tick();
    MDR_LOAD = 1'b0; RAM_LOAD = 1'b0;
    total++;
    if ({rdata_out, mem_req, mem_we} !== {16'h1111, 2'b10}) begin
      bad++;
      $display("FAIL inreq_mdr: got mdr=%h req=%b we=%b want mdr=1111 req=1 we=0",
               rdata_out, mem_req, mem_we);
    end
    mem_ack = 1'b1; mem_rdata = 16'h2468;
    tick();
    mem_ack = 1'b0; mem_rdata = 16'hFFFF;
    total++;
    if (rdata_out !== 16'h2468) begin
      bad++;
      $display("FAIL inreq_ack_overwrite: got %h want 2468", rdata_out);
    end
    extra = 0;
    repeat (3) begin
      tick();
      if (mem_req) extra++;
    end
    total++;
    if (extra != 0 || rdata_out !== 16'h2468) begin
      bad++;
      $display("FAIL inreq_ignored: got %0d request cycles mdr=%h want 0 and 2468", extra, rdata_out);
    end
    RE = 1'b0;
    tick();
  endtask

`ifdef MEMCTL_TIMEOUT_EN
  task automatic test_timeout();
    int req_cyc, fault_cyc, fault_at, req_last;
    logic [15:0] mdr_before;
    mdr_before = rdata_out;
    MAR_LOAD = 1'b1; addr_in = 16'h0155; BE = 1'b0; RE = 1'b1;
    tick();
    MAR_LOAD = 1'b0; addr_in = 16'h0abc;
    req_cyc = 0; fault_cyc = 0; fault_at = -1; req_last = -1;
    for (int i = 0; i < 20; i++) begin
      if (mem_req) begin
        req_cyc++;
        req_last = i;
      end
      if (fault_r) begin
        fault_cyc++;
        fault_at = i;
      end
      tick();
    end
    total++;
    if (req_cyc != 15 || fault_cyc != 1 || fault_at != req_last + 1) begin
      bad++;
      $display("FAIL timeout_timing: got req=%0d fault=%0d at=%0d want req=15 fault=1 at=15",
               req_cyc, fault_cyc, fault_at);
    end
    total++;
    if (fault_addr !== 16'h0155 || rdata_out !== mdr_before) begin
      bad++;
      $display("FAIL timeout_addr: got faddr=%h mdr=%h want 0155 and %h",
               fault_addr, rdata_out, mdr_before);
    end
    RE = 1'b0;
    tick();
    access(1'b0, 1'b0, 16'h0046, 16'h0000, 15, 1'b0, 1'b0);
  endtask
`endif

  task automatic test_reset_mid();
    int faults;
    MAR_LOAD = 1'b1; addr_in = 16'h0066; MDR_LOAD = 1'b1; wdata_in = 16'h9999;
    BE = 1'b0; RAM_LOAD = 1'b1;
    tick();
    MAR_LOAD = 1'b0; MDR_LOAD = 1'b0; RAM_LOAD = 1'b0;
    total++;
    if (mem_req !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_start: got req=%b want 1", mem_req);
    end
    reset = 1'b1;
    tick();
    test_reset();
    reset = 1'b0;
    faults = 0;
    repeat (20) begin
      tick();
      if (fault_r || mem_req) faults++;
    end
    total++;
    if (faults != 0) begin
      bad++;
      $display("FAIL rstmid_quiet: got %0d fault/req cycles want 0", faults);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      access(1'($urandom), 1'($urandom), 16'($urandom_range(0, 511)), 16'($urandom),
             int'($urandom_range(1, 6)), 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    tick();
    tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_directed();
    test_re_level();
    test_back_to_back();
`ifdef MEMCTL_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
